div_sqrt_iter_mvp: RTL

- Iterative radix-2 mantissa divider/square-rooter.
- Sits directly downstream of the operand preprocess/normalisation stage. Consumes its registered normalised exponents and mantissas (hidden bit at MSB) plus the start strobe.
- Produces a raw, MSB-aligned quotient/root, a sticky bit and a biased result exponent for the normalise/round stage.
- One operation in flight; iteration count depends on format.

---
 rtl/div_sqrt_iter_mvp_if.sv | 33 +++
 rtl/div_sqrt_iter_mvp.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/div_sqrt_iter_mvp_if.sv
// Operand/result bundle between the preprocess stage, the iterative
// divider/square-rooter and the normalise/round stage.
interface div_sqrt_iter_mvp_if #(
  parameter int unsigned C_MANT = 52,
  parameter int unsigned C_EXP  = 11
);
  logic                Start_SI;
  logic                Div_start_SI;
  logic                Sqrt_start_SI;
  logic [1:0]          Format_sel_SI;
  logic                Kill_SI;
  logic [C_EXP:0]      Exp_a_DI;
  logic [C_EXP:0]      Exp_b_DI;
  logic [C_MANT:0]     Mant_a_DI;
  logic [C_MANT:0]     Mant_b_DI;
  logic                Ready_SO;
  logic                Done_SO;
  logic [C_MANT+2:0]   Quot_DO;
  logic                Sticky_SO;
  logic [C_EXP+1:0]    Exp_z_DO;

  modport master (
    output Start_SI, Div_start_SI, Sqrt_start_SI, Format_sel_SI, Kill_SI,
    output Exp_a_DI, Exp_b_DI, Mant_a_DI, Mant_b_DI,
    input  Ready_SO, Done_SO, Quot_DO, Sticky_SO, Exp_z_DO
  );

  modport slave (
    input  Start_SI, Div_start_SI, Sqrt_start_SI, Format_sel_SI, Kill_SI,
    input  Exp_a_DI, Exp_b_DI, Mant_a_DI, Mant_b_DI,
    output Ready_SO, Done_SO, Quot_DO, Sticky_SO, Exp_z_DO
  );
endinterface

// File: rtl/div_sqrt_iter_mvp.sv
// Iterative radix-2 mantissa divider / square-rooter: one result bit per
// cycle, MSB first, raw left-aligned result plus sticky and biased exponent.
module div_sqrt_iter_mvp #(
  parameter int unsigned C_MANT = 52,
  parameter int unsigned C_EXP  = 11
) (
  input logic Clk_CI,
  input logic Rst_RBI,
  div_sqrt_iter_mvp_if.slave dsq
);

  localparam int unsigned C_M   = C_MANT + 1;
  localparam int unsigned C_Q   = C_MANT + 3;
  localparam int unsigned C_RAD = C_MANT + 2;
  localparam int unsigned C_REM = C_MANT + 6;
  localparam int unsigned C_EZ  = C_EXP + 2;
  localparam int unsigned C_CNT = $clog2(C_Q + 1);
  localparam logic [C_EZ-1:0] C_BIAS_FP64 = C_EZ'((1 << (C_EXP - 1)) - 1);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

  state_e state_q, state_d;

  logic                  is_sqrt_q;
  logic [1:0]            fmt_q;
  logic [C_CNT-1:0]      iter_n_q;
  logic [C_CNT-1:0]      cnt_q;
  logic [C_REM-1:0]      rem_q;
  logic [C_Q-1:0]        quot_q;
  logic [C_M-1:0]        divisor_q;
  logic [C_RAD-1:0]      rad_q;
  logic [C_EZ-1:0]       exp_q;

  logic                  ready_q;
  logic                  done_q;
  logic [C_Q-1:0]        quot_out_q;
  logic                  sticky_q;
  logic [C_EZ-1:0]       exp_z_q;

  function automatic logic [C_CNT-1:0] iter_count(input logic [1:0] fmt);
    case (fmt)
      2'b00:   return C_CNT'(26);
      2'b01:   return C_CNT'(C_Q);
      2'b10:   return C_CNT'(13);
      default: return C_CNT'(10);
    endcase
  endfunction

  function automatic logic [C_EZ-1:0] bias_of(input logic [1:0] fmt);
    case (fmt)
      2'b00:   return C_EZ'(127);
      2'b01:   return C_BIAS_FP64;
      2'b10:   return C_EZ'(15);
      default: return C_EZ'(127);
    endcase
  endfunction

  logic start_ok;
  logic last_iter;

  assign start_ok  = dsq.Start_SI & (dsq.Div_start_SI ^ dsq.Sqrt_start_SI);
  assign last_iter = (cnt_q == C_CNT'(1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_ok) state_d = LOAD;
      LOAD: state_d = dsq.Kill_SI ? IDLE : ITER;
      ITER: begin
        if (dsq.Kill_SI)    state_d = IDLE;
        else if (last_iter) state_d = DONE;
      end
      DONE: state_d = start_ok ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // One recurrence step for both operations; the op flag picks the result
  logic [C_REM-1:0] div_ext, div_rem_d, sq_shift, sq_trial, sq_rem_d, rem_step;
  logic             div_ge, sq_ge, q_bit;
  logic [C_Q-1:0]   quot_step;

  always_comb begin
    div_ext   = C_REM'(divisor_q);
    div_ge    = (rem_q >= div_ext);
    div_rem_d = (div_ge ? (rem_q - div_ext) : rem_q) << 1;
    sq_shift  = {rem_q[C_REM-3:0], rad_q[C_RAD-1 -: 2]};
    sq_trial  = C_REM'({quot_q, 2'b01});
    sq_ge     = (sq_shift >= sq_trial);
    sq_rem_d  = sq_ge ? (sq_shift - sq_trial) : sq_shift;
    rem_step  = is_sqrt_q ? sq_rem_d : div_rem_d;
    q_bit     = is_sqrt_q ? sq_ge : div_ge;
    quot_step = {quot_q[C_Q-2:0], q_bit};
  end

  // Operand-dependent initial values, evaluated in LOAD
  logic signed [C_EZ-1:0] exp_a_s, exp_b_s, bias_s, sq_unb, exp_div, exp_sqrt;
  logic [C_RAD-1:0]       rad_load;

  always_comb begin
    exp_a_s  = C_EZ'($signed(dsq.Exp_a_DI));
    exp_b_s  = C_EZ'($signed(dsq.Exp_b_DI));
    bias_s   = $signed(bias_of(fmt_q));
    exp_div  = exp_a_s - exp_b_s + bias_s;
    sq_unb   = exp_a_s - bias_s;
    exp_sqrt = (sq_unb >>> 1) + bias_s;
    // Odd unbiased exponent folds one factor of two into the radicand
    rad_load = sq_unb[0] ? {dsq.Mant_a_DI, 1'b0} : {1'b0, dsq.Mant_a_DI};
  end

  // Datapath and registered outputs
  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      is_sqrt_q  <= 1'b0;
      fmt_q      <= '0;
      iter_n_q   <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      rad_q      <= '0;
      exp_q      <= '0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      quot_out_q <= '0;
      sticky_q   <= 1'b0;
      exp_z_q    <= '0;
    end else begin
      ready_q <= (state_d == IDLE) || (state_d == DONE);
      done_q  <= (state_d == DONE);
      case (state_q)
        IDLE, DONE: begin
          if (start_ok) begin
            is_sqrt_q <= dsq.Sqrt_start_SI;
            fmt_q     <= dsq.Format_sel_SI;
            iter_n_q  <= iter_count(dsq.Format_sel_SI);
          end
        end
        LOAD: begin
          if (!dsq.Kill_SI) begin
            divisor_q <= dsq.Mant_b_DI;
            rad_q     <= rad_load;
            rem_q     <= is_sqrt_q ? '0 : C_REM'(dsq.Mant_a_DI);
            quot_q    <= '0;
            cnt_q     <= iter_n_q;
            exp_q     <= is_sqrt_q ? exp_sqrt : exp_div;
          end
        end
        ITER: begin
          if (!dsq.Kill_SI) begin
            rem_q  <= rem_step;
            quot_q <= quot_step;
            rad_q  <= rad_q << 2;
            cnt_q  <= cnt_q - C_CNT'(1);
            if (last_iter) begin
              quot_out_q <= quot_step << (C_CNT'(C_Q) - iter_n_q);
              sticky_q   <= |rem_step;
              exp_z_q    <= exp_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dsq.Ready_SO  = ready_q;
  assign dsq.Done_SO   = done_q;
  assign dsq.Quot_DO   = quot_out_q;
  assign dsq.Sticky_SO = sticky_q;
  assign dsq.Exp_z_DO  = exp_z_q;

endmodule
